// File: rtl/mc_controller_v2.sv
// mc_controller_v2: multicycle RV32I-subset control FSM with a retired-instruction counter.
// Control strobes are decoded from the current state. PCWrite, IRWrite and MemWrite may
// also depend on the ALU flags and on the memory handshake. illegal and instret are registered.
module mc_controller_v2 #(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned TRAP_EN       = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             zero,
    input  logic             branchLEG,
    input  logic [6:0]       op,
    input  logic [6:0]       func7,
    input  logic [2:0]       func3,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             mem_req,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [2:0]       ImmSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [4:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB,
        S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH,
        S_JALR_LINK, S_JALR_WB, S_JALR_JMP,
        S_JAL_LINK, S_JAL_WB, S_JAL_JMP,
        S_LUI, S_AUIPC, S_TRAP
    } state_t;

    // Destination for an unsupported encoding.
    localparam state_t S_BAD = (TRAP_EN != 0) ? S_TRAP : S_FETCH;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_rdy;
    logic             w_retire;
    logic             w_r_ok;
    logic             w_i_ok;
    logic             w_b_ok;
    logic             w_b_take;
    logic [2:0]       w_r_alu;
    logic [2:0]       w_i_alu;
    logic [2:0]       w_b_alu;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instret;

    // Memory completion: mem_ready is ignored when memory is single-cycle.
    assign w_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // Funct-field decode for register ALU ops, immediate ALU ops and branches.
    always_comb begin
        w_r_ok   = 1'b1;
        w_r_alu  = ALU_ADD;
        w_i_ok   = 1'b1;
        w_i_alu  = ALU_ADD;
        w_b_ok   = 1'b1;
        w_b_alu  = ALU_SUB;
        w_b_take = 1'b0;
        case ({func7, func3})
            {F7_BASE, 3'b000}: w_r_alu = ALU_ADD;
            {F7_ALT,  3'b000}: w_r_alu = ALU_SUB;
            {F7_BASE, 3'b111}: w_r_alu = ALU_AND;
            {F7_BASE, 3'b110}: w_r_alu = ALU_OR;
            {F7_BASE, 3'b100}: w_r_alu = ALU_XOR;
            {F7_BASE, 3'b010}: w_r_alu = ALU_SLT;
            default: begin
                w_r_ok  = 1'b0;
                w_r_alu = ALU_AND;
            end
        endcase
        case (func3)
            3'b000:  w_i_alu = ALU_ADD;
            3'b100:  w_i_alu = ALU_XOR;
            3'b110:  w_i_alu = ALU_OR;
            3'b111:  w_i_alu = ALU_AND;
            3'b010:  w_i_alu = ALU_SLT;
            default: begin
                w_i_ok  = 1'b0;
                w_i_alu = ALU_AND;
            end
        endcase
        case (func3)
            3'b000:  w_b_take = zero;
            3'b001:  w_b_take = ~zero;
            3'b100: begin
                w_b_alu  = ALU_SLT;
                w_b_take = branchLEG;
            end
            3'b101: begin
                w_b_alu  = ALU_SLT;
                w_b_take = ~branchLEG;
            end
            default: w_b_ok = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; w_retire marks a terminal state completing an instruction.
    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH:     if (w_rdy) w_state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_R:               w_state_next = S_EXEC_R;
                    OP_I:               w_state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:  w_state_next = S_MEM_ADR;
                    OP_BRANCH:          w_state_next = S_BRANCH;
                    OP_JALR:            w_state_next = S_JALR_LINK;
                    OP_JAL:             w_state_next = S_JAL_LINK;
                    OP_LUI:             w_state_next = S_LUI;
                    OP_AUIPC:           w_state_next = S_AUIPC;
                    default:            w_state_next = S_BAD;
                endcase
            end
            S_EXEC_R:    w_state_next = w_r_ok ? S_ALU_WB : S_BAD;
            S_EXEC_I:    w_state_next = w_i_ok ? S_ALU_WB : S_BAD;
            S_MEM_ADR:   w_state_next = op[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    if (w_rdy) w_state_next = S_MEM_WB;
            S_MEM_WR: begin
                if (w_rdy) begin
                    w_state_next = S_FETCH;
                    w_retire     = 1'b1;
                end
            end
            S_BRANCH: begin
                w_state_next = w_b_ok ? S_FETCH : S_BAD;
                w_retire     = w_b_ok;
            end
            S_JALR_LINK: w_state_next = S_JALR_WB;
            S_JALR_WB:   w_state_next = S_JALR_JMP;
            S_JAL_LINK:  w_state_next = S_JAL_WB;
            S_JAL_WB:    w_state_next = S_JAL_JMP;
            S_AUIPC:     w_state_next = S_ALU_WB;
            S_ALU_WB, S_MEM_WB, S_JALR_JMP, S_JAL_JMP, S_LUI: begin
                w_state_next = S_FETCH;
                w_retire     = 1'b1;
            end
            S_TRAP:      w_state_next = S_TRAP;
            default:     w_state_next = S_FETCH;
        endcase
    end

    // Output decode; everything not driven by a state stays 0.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        mem_req    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        ImmSrc     = 3'b000;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                ResultSrc  = 2'b10;
                IRWrite    = w_rdy;
                PCWrite    = w_rdy;
            end
            S_DECODE: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ImmSrc     = 3'b010;
                ALUControl = ALU_ADD;
            end
            S_EXEC_R: begin
                ALUSrcA    = 2'b10;
                ALUControl = w_r_alu;
            end
            S_EXEC_I: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = w_i_alu;
            end
            S_ALU_WB, S_JALR_WB, S_JAL_WB: RegWrite = 1'b1;
            S_MEM_ADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                ImmSrc     = op[5] ? 3'b001 : 3'b000;
            end
            S_MEM_RD: begin
                AdrSrc  = 1'b1;
                mem_req = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite  = 1'b1;
                ResultSrc = 2'b01;
            end
            S_MEM_WR: begin
                AdrSrc   = 1'b1;
                mem_req  = 1'b1;
                MemWrite = w_rdy;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = w_b_alu;
                PCWrite    = w_b_take;
            end
            S_JALR_LINK, S_JAL_LINK: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_JALR_JMP: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
            end
            S_JAL_JMP: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                ImmSrc     = 3'b011;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
            end
            S_LUI: begin
                ImmSrc    = 3'b100;
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
            end
            S_AUIPC: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                ImmSrc     = 3'b100;
            end
            default: ;
        endcase
    end

    // Sticky trap flag and retired-instruction counter (wraps naturally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            r_illegal <= r_illegal | (w_state_next == S_TRAP);
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    assign illegal = r_illegal;
    assign instret = r_instret;

endmodule

// File: tb/tb_mc_controller_v2.sv
// tb_mc_controller_v2: directed and randomized checks of the multicycle controller.
// Instance A: handshake on, traps on, 32-bit counter. Instance B: single-cycle memory, no traps, 8-bit counter.
module tb_mc_controller_v2;

    logic       clk = 1'b0;
    logic       rst_a_n, rst_b_n;
    logic       zero, branchLEG, mem_ready;
    logic [6:0] op, func7;
    logic [2:0] func3;

    logic        a_PCWrite, a_AdrSrc, a_MemWrite, a_IRWrite, a_RegWrite, a_mem_req, a_illegal;
    logic [1:0]  a_ResultSrc, a_ALUSrcA, a_ALUSrcB;
    logic [2:0]  a_ALUControl, a_ImmSrc;
    logic [31:0] a_instret;
    logic        b_PCWrite, b_AdrSrc, b_MemWrite, b_IRWrite, b_RegWrite, b_mem_req, b_illegal;
    logic [1:0]  b_ResultSrc, b_ALUSrcA, b_ALUSrcB;
    logic [2:0]  b_ALUControl, b_ImmSrc;
    logic [7:0]  b_instret;

    mc_controller_v2 #(.MEM_HANDSHAKE(1), .TRAP_EN(1), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst_n(rst_a_n), .zero(zero), .branchLEG(branchLEG), .op(op), .func7(func7),
        .func3(func3), .mem_ready(mem_ready), .PCWrite(a_PCWrite), .AdrSrc(a_AdrSrc),
        .MemWrite(a_MemWrite), .IRWrite(a_IRWrite), .RegWrite(a_RegWrite), .mem_req(a_mem_req),
        .ResultSrc(a_ResultSrc), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB),
        .ALUControl(a_ALUControl), .ImmSrc(a_ImmSrc), .illegal(a_illegal), .instret(a_instret)
    );

    mc_controller_v2 #(.MEM_HANDSHAKE(0), .TRAP_EN(0), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_b_n), .zero(zero), .branchLEG(branchLEG), .op(op), .func7(func7),
        .func3(func3), .mem_ready(mem_ready), .PCWrite(b_PCWrite), .AdrSrc(b_AdrSrc),
        .MemWrite(b_MemWrite), .IRWrite(b_IRWrite), .RegWrite(b_RegWrite), .mem_req(b_mem_req),
        .ResultSrc(b_ResultSrc), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
        .ALUControl(b_ALUControl), .ImmSrc(b_ImmSrc), .illegal(b_illegal), .instret(b_instret)
    );

    always #5 clk = ~clk;

    // Observed control bundle: {PCW,AdrSrc,MemW,IRW,RegW,mem_req,ResultSrc,SrcA,SrcB,ALUCtl,ImmSrc}
    logic [17:0] obs_a, obs_b;
    assign obs_a = {a_PCWrite, a_AdrSrc, a_MemWrite, a_IRWrite, a_RegWrite, a_mem_req,
                    a_ResultSrc, a_ALUSrcA, a_ALUSrcB, a_ALUControl, a_ImmSrc};
    assign obs_b = {b_PCWrite, b_AdrSrc, b_MemWrite, b_IRWrite, b_RegWrite, b_mem_req,
                    b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ALUControl, b_ImmSrc};

    localparam logic [17:0] ALL    = 18'h3FFFF;
    localparam logic [17:0] NO_ALU = 18'h3FFC7;

    int total_n = 0;
    int bad_n   = 0;
    int pcw_n, irw_n, rw_n, mw_n;

    // Reference model state: expected per-cycle controls and retired-instruction counts.
    logic        q_mr[$];
    logic [17:0] q_exp[$];
    logic [17:0] q_msk[$];
    bit          m_retire, m_bad;
    logic [31:0] exp_a;
    logic [7:0]  exp_b;

    logic [9:0] r_tab[6];
    logic [2:0] i_tab[5];
    logic [2:0] b_tab[4];

    function automatic logic [17:0] cv(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic mreq,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] alu,
                                       input logic [2:0] imm);
        return {pcw, adr, mw, irw, rw, mreq, rs, sa, sb, alu, imm};
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    // R-type {func7,func3} -> {legal, ALU op}
    function automatic logic [3:0] r_ref(input logic [6:0] f7, input logic [2:0] f3);
        case ({f7, f3})
            10'b0000000_000: return 4'b1_010;
            10'b0100000_000: return 4'b1_110;
            10'b0000000_111: return 4'b1_000;
            10'b0000000_110: return 4'b1_001;
            10'b0000000_100: return 4'b1_011;
            10'b0000000_010: return 4'b1_111;
            default:         return 4'b0_000;
        endcase
    endfunction

    // I-type func3 -> {legal, ALU op}
    function automatic logic [3:0] i_ref(input logic [2:0] f3);
        case (f3)
            3'b000:  return 4'b1_010;
            3'b100:  return 4'b1_011;
            3'b110:  return 4'b1_001;
            3'b111:  return 4'b1_000;
            3'b010:  return 4'b1_111;
            default: return 4'b0_000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_n++;
        assert (got === exp) else begin
            bad_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic mr, input logic [17:0] e, input logic [17:0] m);
        q_mr.push_back(mr);
        q_exp.push_back(e);
        q_msk.push_back(m);
    endtask

    // Drives the instruction fields and builds the expected cycle-by-cycle control sequence.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z, input logic l, input int nf, input int nm, input bit hs);
        logic [3:0]  d;
        logic        take;
        logic [17:0] wait_v;
        op = o; func3 = f3; func7 = f7; zero = z; branchLEG = l;
        q_mr.delete(); q_exp.delete(); q_msk.delete();
        m_retire = 1'b0;
        m_bad    = 1'b0;
        for (int i = 0; i < nf; i++) push(1'b0, cv(0,0,0,0,0,1,2'b10,2'b00,2'b10,3'b010,3'b000), ALL);
        push(hs ? 1'b1 : rnd(), cv(1,0,0,1,0,1,2'b10,2'b00,2'b10,3'b010,3'b000), ALL);
        push(rnd(), cv(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b010,3'b010), ALL);
        case (o)
            7'b0110011, 7'b0010011: begin
                d = (o == 7'b0110011) ? r_ref(f7, f3) : i_ref(f3);
                push(rnd(), cv(0,0,0,0,0,0,2'b00,2'b10,(o == 7'b0110011) ? 2'b00 : 2'b01,d[2:0],3'b000),
                     d[3] ? ALL : NO_ALU);
                if (d[3]) begin
                    push(rnd(), cv(0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000,3'b000), ALL);
                    m_retire = 1'b1;
                end else begin
                    m_bad = 1'b1;
                end
            end
            7'b0000011, 7'b0100011: begin
                push(rnd(), cv(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b010,o[5] ? 3'b001 : 3'b000), ALL);
                wait_v = cv(0,1,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000);
                for (int i = 0; i < nm; i++) push(1'b0, wait_v, ALL);
                if (o[5]) begin
                    push(hs ? 1'b1 : rnd(), cv(0,1,1,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000), ALL);
                end else begin
                    push(hs ? 1'b1 : rnd(), wait_v, ALL);
                    push(rnd(), cv(0,0,0,0,1,0,2'b01,2'b00,2'b00,3'b000,3'b000), ALL);
                end
                m_retire = 1'b1;
            end
            7'b1100011: begin
                take = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : (f3 == 3'b100) ? l : !l;
                if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101) begin
                    push(rnd(), cv(take,0,0,0,0,0,2'b00,2'b10,2'b00,f3[2] ? 3'b111 : 3'b110,3'b000), ALL);
                    m_retire = 1'b1;
                end else begin
                    push(rnd(), cv(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b000), NO_ALU);
                    m_bad = 1'b1;
                end
            end
            7'b1100111, 7'b1101111: begin
                push(rnd(), cv(0,0,0,0,0,0,2'b00,2'b01,2'b10,3'b010,3'b000), ALL);
                push(rnd(), cv(0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000,3'b000), ALL);
                if (o[3]) push(rnd(), cv(1,0,0,0,0,0,2'b10,2'b01,2'b01,3'b010,3'b011), ALL);
                else      push(rnd(), cv(1,0,0,0,0,0,2'b10,2'b10,2'b01,3'b010,3'b000), ALL);
                m_retire = 1'b1;
            end
            7'b0110111: begin
                push(rnd(), cv(0,0,0,0,1,0,2'b11,2'b00,2'b00,3'b000,3'b100), ALL);
                m_retire = 1'b1;
            end
            7'b0010111: begin
                push(rnd(), cv(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b010,3'b100), ALL);
                push(rnd(), cv(0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000,3'b000), ALL);
                m_retire = 1'b1;
            end
            default: m_bad = 1'b1;
        endcase
    endtask

    // Steps through the expected sequence; entered and left on a falling edge.
    task automatic run(input bit sel, input int limit);
        int          n;
        logic [17:0] obs;
        n = (limit < q_exp.size()) ? limit : q_exp.size();
        pcw_n = 0; irw_n = 0; rw_n = 0; mw_n = 0;
        for (int i = 0; i < n; i++) begin
            mem_ready = q_mr[i];
            #1;
            obs = sel ? obs_b : obs_a;
            if (i == 0) begin
                if (sel) begin
                    chk("instret_b", 64'(b_instret), 64'(exp_b));
                    chk("illegal_b", 64'(b_illegal), 64'd0);
                end else begin
                    chk("instret_a", 64'(a_instret), 64'(exp_a));
                    chk("illegal_a", 64'(a_illegal), 64'd0);
                end
            end
            chk($sformatf("ctl[%0d] dut=%0d op=%02h f3=%0d", i, sel, op, func3),
                64'(obs & q_msk[i]), 64'(q_exp[i] & q_msk[i]));
            if (obs[17]) pcw_n++;
            if (obs[14]) irw_n++;
            if (obs[13]) rw_n++;
            if (obs[15]) mw_n++;
            @(negedge clk);
        end
        if (n == q_exp.size() && m_retire) begin
            if (sel) exp_b = exp_b + 8'd1;
            else     exp_a = exp_a + 32'd1;
        end
    endtask

    // Confirms the DUT is back in FETCH (idle controls with mem_ready low).
    task automatic chk_fetch(input bit sel, input string tag);
        mem_ready = 1'b0;
        #1;
        if (sel) chk(tag, 64'(obs_b), 64'(cv(1,0,0,1,0,1,2'b10,2'b00,2'b10,3'b010,3'b000)));
        else     chk(tag, 64'(obs_a), 64'(cv(0,0,0,0,0,1,2'b10,2'b00,2'b10,3'b010,3'b000)));
    endtask

    task automatic reset_a();
        rst_a_n   = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rst_a_ctl_idle", 64'(obs_a), 64'(cv(0,0,0,0,0,1,2'b10,2'b00,2'b10,3'b010,3'b000)));
        chk("rst_a_illegal", 64'(a_illegal), 64'd0);
        chk("rst_a_instret", 64'(a_instret), 64'd0);
        mem_ready = 1'b1;
        #1;
        chk("rst_a_ctl_rdy", 64'(obs_a), 64'(cv(1,0,0,1,0,1,2'b10,2'b00,2'b10,3'b010,3'b000)));
        @(negedge clk);
        mem_ready = 1'b0;
        rst_a_n   = 1'b1;
        exp_a     = '0;
    endtask

    task automatic reset_b();
        rst_b_n = 1'b0;
        #1;
        chk("rst_b_ctl", 64'(obs_b), 64'(cv(1,0,0,1,0,1,2'b10,2'b00,2'b10,3'b010,3'b000)));
        chk("rst_b_instret", 64'(b_instret), 64'd0);
        @(negedge clk);
        rst_b_n = 1'b1;
        exp_b   = '0;
    endtask

    // Random supported instruction.
    task automatic pick_legal(output logic [6:0] o, output logic [2:0] f3, output logic [6:0] f7);
        int k;
        k  = $urandom_range(0, 8);
        f7 = 7'($urandom);
        f3 = 3'($urandom);
        case (k)
            0: begin o = 7'b0110011; {f7, f3} = r_tab[$urandom_range(0, 5)]; end
            1: begin o = 7'b0010011; f3 = i_tab[$urandom_range(0, 4)]; end
            2: begin o = 7'b0000011; f3 = 3'b010; end
            3: begin o = 7'b0100011; f3 = 3'b010; end
            4: begin o = 7'b1100011; f3 = b_tab[$urandom_range(0, 3)]; end
            5: o = 7'b1100111;
            6: o = 7'b1101111;
            7: o = 7'b0110111;
            default: o = 7'b0010111;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] o, f7;
        logic [2:0] f3;
        r_tab = '{10'b0000000_000, 10'b0100000_000, 10'b0000000_111,
                  10'b0000000_110, 10'b0000000_100, 10'b0000000_010};
        i_tab = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b010};
        b_tab = '{3'b000, 3'b001, 3'b100, 3'b101};
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        zero = 1'b0; branchLEG = 1'b0; mem_ready = 1'b0;
        op = '0; func3 = '0; func7 = '0;
        exp_a = '0; exp_b = '0;
        @(negedge clk);
        reset_a();

        // add, single-cycle memory timing: 4 cycles, counter 0 -> 1
        build(7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0, 0, 0, 1'b1);
        run(1'b0, 100);
        chk_fetch(1'b0, "add_len");
        chk("add_instret", 64'(a_instret), 64'd1);

        // lw with two stall cycles in both FETCH and MEM_RD: 9 cycles
        build(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0, 2, 2, 1'b1);
        run(1'b0, 100);
        chk_fetch(1'b0, "lw_len");
        chk("lw_irw_n", 64'(irw_n), 64'd1);
        chk("lw_pcw_n", 64'(pcw_n), 64'd1);
        chk("lw_rw_n", 64'(rw_n), 64'd1);

        // bne taken then not taken: 3 cycles each
        build(7'b1100011, 3'b001, 7'b0000000, 1'b0, 1'b0, 0, 0, 1'b1);
        run(1'b0, 100);
        chk_fetch(1'b0, "bne_t_len");
        chk("bne_t_pcw_n", 64'(pcw_n), 64'd2);
        build(7'b1100011, 3'b001, 7'b0000000, 1'b1, 1'b0, 0, 0, 1'b1);
        run(1'b0, 100);
        chk_fetch(1'b0, "bne_nt_len");
        chk("bne_nt_pcw_n", 64'(pcw_n), 64'd1);

        // random supported instructions with random stalls
        for (int n = 0; n < 80; n++) begin
            pick_legal(o, f3, f7);
            build(o, f3, f7, rnd(), rnd(), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
            run(1'b0, 100);
        end
        chk_fetch(1'b0, "rand_a_end");
        chk("rand_a_instret", 64'(a_instret), 64'(exp_a));

        // reset while a store is stalled: no write strobe, back to FETCH
        build(7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0, 0, 5, 1'b1);
        run(1'b0, 5);
        mem_ready = 1'b0;
        #1;
        chk("sw_stall_ctl", 64'(obs_a), 64'(cv(0,1,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000)));
        chk("sw_stall_mw_n", 64'(mw_n), 64'd0);
        reset_a();

        // unsupported encodings enter TRAP and hold until reset
        for (int t = 0; t < 4; t++) begin
            case (t)
                0: build(7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b0, 0, 0, 1'b1);
                1: build(7'b0110011, 3'b000, 7'b0000001, 1'b0, 1'b0, 0, 0, 1'b1);
                2: build(7'b0010011, 3'b001, 7'b0000000, 1'b0, 1'b0, 0, 0, 1'b1);
                default: build(7'b1100011, 3'b010, 7'b0000000, 1'b1, 1'b1, 0, 0, 1'b1);
            endcase
            run(1'b0, 100);
            for (int c = 0; c < 10; c++) begin
                mem_ready = rnd(); zero = rnd(); branchLEG = rnd();
                #1;
                chk($sformatf("trap%0d_ctl", t), 64'(obs_a), 64'd0);
                chk($sformatf("trap%0d_illegal", t), 64'(a_illegal), 64'd1);
                chk($sformatf("trap%0d_instret", t), 64'(a_instret), 64'(exp_a));
                @(negedge clk);
            end
            reset_a();
        end

        // instance B: single-cycle memory, unsupported encodings fall back to FETCH
        rst_a_n = 1'b0;
        reset_b();
        build(7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0, 0, 0, 1'b0);
        run(1'b1, 100);
        chk_fetch(1'b1, "b_add_len");
        build(7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b0, 0, 0, 1'b0);
        run(1'b1, 100);
        chk_fetch(1'b1, "b_bad_to_fetch");
        chk("b_bad_illegal", 64'(b_illegal), 64'd0);
        chk("b_bad_instret", 64'(b_instret), 64'd1);
        for (int n = 0; n < 40; n++) begin
            if (rnd()) pick_legal(o, f3, f7);
            else begin o = 7'($urandom); f3 = 3'($urandom); f7 = 7'($urandom); end
            build(o, f3, f7, rnd(), rnd(), 0, 0, 1'b0);
            run(1'b1, 100);
        end
        chk_fetch(1'b1, "rand_b_end");
        chk("rand_b_instret", 64'(b_instret), 64'(exp_b));

        // 256 addi on the 8-bit counter wraps to 0
        reset_b();
        for (int n = 0; n < 256; n++) begin
            build(7'b0010011, 3'b000, 7'($urandom), rnd(), rnd(), 0, 0, 1'b0);
            run(1'b1, 100);
            if (n == 254) chk("wrap_255", 64'(b_instret), 64'd255);
        end
        chk("wrap_0", 64'(b_instret), 64'd0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
